crc_encoder: RTL and testbench
==============================

CRC_ENCODER -- requirements
Module: crc_encoder

Interface
REQ-001 The block SHALL use one clock and one reset: reset is asynchronous and active-low.
REQ-002 Port clk  input  1  rising-edge clock.
REQ-003 Port rst_b  input  1  asynchronous active-low reset.
REQ-004 Port pktInAvail  input  1  a packet request is presented this cycle.
REQ-005 Port pid  input  4  packet PID.
REQ-006 Port addr  input  7  token address field.
REQ-007 Port endp  input  4  token endpoint field.
REQ-008 Port data  input  64  data payload.
REQ-009 Port readyIn  output  1  encoder can accept a packet request.
REQ-010 Port bitOutReady  input  1  downstream accepts the current bit.
REQ-011 Port bitOutAvail  output  1  bitOut is valid.
REQ-012 Port bitOut  output  1  serial stream bit.
REQ-013 Port done  output  1  one-cycle pulse with the final accepted bit.
REQ-014 Port err  output  1  one-cycle pulse when an unsupported PID is accepted.

Function
REQ-015 Packet class SHALL be token if pid[3:1]==3'b100, data if pid==4'b1100, handshake if pid[3:1]==3'b010; any other PID SHALL be unsupported.
REQ-016 A request SHALL be accepted on a cycle with pktInAvail && readyIn; pid, addr, endp and data SHALL be captured at that point, and later input changes SHALL be ignored.
REQ-017 readyIn SHALL be 1 only in Idle.
REQ-018 Accepting an unsupported PID SHALL pulse err the next cycle, emit no bits, and remain in Idle.
REQ-019 Stream order SHALL be: sync 8'b00000001, then {pid, ~pid}, then the body, then the CRC. Every field SHALL be sent MSB first.
REQ-020 Body SHALL be {addr, endp} (11 bits) for a token, data[63:0] for a data packet, and empty for a handshake.
REQ-021 CRC5 (tokens) SHALL use polynomial x^5+x^2+1 over the 11 body bits, seeded 5'b11111, with the result complemented.
REQ-022 CRC16 (data) SHALL use polynomial x^16+x^15+x^2+1 over the 64 body bits, seeded 16'hFFFF, with the result complemented.
REQ-023 Total lengths SHALL be 16 bits (handshake), 32 bits (token) and 96 bits (data).
REQ-024 The FSM SHALL have the states Idle, Sync, Pid, Body and Crc, with these transitions:
  - Idle->Sync on a supported accept;
  - Sync->Pid after 8 bits;
  - Pid->Body after 8 bits for token/data;
  - Pid->Idle for a handshake;
  - Body->Crc after 11 or 64 bits;
  - Crc->Idle after 5 or 16 bits.
REQ-025 A bit SHALL advance only on a cycle with bitOutAvail && bitOutReady. When bitOutReady is low, bitOut and the state SHALL hold.
REQ-026 bitOutAvail SHALL be 1 in every state except Idle. The first bit SHALL be available on the cycle after accept.
REQ-027 The CRC register SHALL update only as a body bit is accepted downstream. Its complement SHALL be frozen on entry to Crc and shifted out MSB first.
REQ-028 done SHALL assert on the same cycle the last bit is accepted. The FSM SHALL be in Idle with readyIn=1 on the next cycle, so back-to-back packets leave a one-cycle gap.
REQ-029 Bit counters SHALL be 7 bits wide and SHALL clear on each state change; no counter SHALL wrap within a field.
REQ-030 With bitOutReady held high, packet latency from accept to done SHALL be exactly N cycles, where N is the packet length.

Reset
REQ-031 Asserting rst_b low SHALL force, at any point including mid-packet, state=Idle, all counters=0, CRC=all ones, bitOut=0, bitOutAvail=0, done=0, err=0, readyIn=1.
REQ-032 A packet interrupted by reset SHALL be abandoned with no done pulse. The first request after rst_b is released SHALL be accepted normally.

Structure
REQ-033 The shared package crc_pkg SHALL hold:
  - the FSM state enum;
  - PID class constants;
  - the polynomial and seed constants;
  - field lengths (8, 8, 11, 64, 5, 16).
REQ-034 There SHALL be one sub-module, crc_lfsr, parameterized by width, polynomial and seed, with ports clk, rst_b, clear, shift_en, din and crc.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
  - Handshake: pid=4'b0100, bitOutReady=1 -> 16 bits 00000001_0100_1011, done on the 16th cycle, then readyIn=1.
  - Token: pid=4'b1000, addr=7'h15, endp=4'hE -> 32 bits. Running the last 16 bits through a seeded CRC5 checker gives residue 5'b01100.
  - Data: pid=4'b1100, data=64'h0123456789ABCDEF -> 96 bits. The last 80 bits through a seeded CRC16 checker give residue 16'h800D. Loopback into the team's packet decoder gives valid=1.
  - Stall: the data packet with bitOutReady toggled every other cycle -> identical bit sequence, 192-cycle latency, and bitOut stable while stalled.
  - Unsupported PID: pid=4'b0000 -> err pulse, no bitOutAvail, readyIn stays 1.
  - Reset mid-token: rst_b low at bit 20 -> outputs at reset values, no done. The next handshake request is emitted correctly.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types and constants for the serial CRC packet encoder:
// FSM states, PID classes, CRC polynomials and seeds, and field lengths.
package crc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_BODY,
    ST_CRC
  } state_t;

  typedef enum logic [1:0] {
    CLS_TOKEN,
    CLS_DATA,
    CLS_HS,
    CLS_BAD
  } pkt_cls_t;

  localparam logic [2:0] PID_TOKEN_PFX = 3'b100;
  localparam logic [2:0] PID_HS_PFX    = 3'b010;
  localparam logic [3:0] PID_DATA      = 4'b1100;

  // Polynomials are written without the implicit top term.
  localparam logic [4:0]  CRC5_POLY  = 5'b00101;
  localparam logic [4:0]  CRC5_SEED  = 5'b11111;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_SEED = 16'hFFFF;

  localparam logic [7:0] SYNC_PATTERN = 8'b00000001;

  localparam logic [6:0] SYNC_LEN       = 7'd8;
  localparam logic [6:0] PID_LEN        = 7'd8;
  localparam logic [6:0] TOKEN_BODY_LEN = 7'd11;
  localparam logic [6:0] DATA_BODY_LEN  = 7'd64;
  localparam logic [6:0] CRC5_LEN       = 7'd5;
  localparam logic [6:0] CRC16_LEN      = 7'd16;

  function automatic pkt_cls_t classify(input logic [3:0] pid);
    pkt_cls_t cls;
    if (pid[3:1] == PID_TOKEN_PFX)   cls = CLS_TOKEN;
    else if (pid == PID_DATA)        cls = CLS_DATA;
    else if (pid[3:1] == PID_HS_PFX) cls = CLS_HS;
    else                             cls = CLS_BAD;
    return cls;
  endfunction

endpackage

// File: rtl/crc_encoder_if.sv
// Request and serial-output signals of the CRC encoder; the encoder is the
// slave, whoever presents packets and drains bits is the master.
interface crc_encoder_if;
  logic        pktInAvail;
  logic [3:0]  pid;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [63:0] data;
  logic        readyIn;
  logic        bitOutReady;
  logic        bitOutAvail;
  logic        bitOut;
  logic        done;
  logic        err;

  modport master (
    output pktInAvail, pid, addr, endp, data, bitOutReady,
    input  readyIn, bitOutAvail, bitOut, done, err
  );

  modport slave (
    input  pktInAvail, pid, addr, endp, data, bitOutReady,
    output readyIn, bitOutAvail, bitOut, done, err
  );
endinterface

// File: rtl/crc_lfsr.sv
// Serial MSB-first CRC register: reseeds on clear, folds din in on shift_en.
module crc_lfsr #(
  parameter int           W    = 5,
  parameter logic [W-1:0] POLY = '0,
  parameter logic [W-1:0] SEED = '1
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] crc
);

  logic [W-1:0] crc_q, crc_d;
  logic         fb;

  always_comb begin
    fb    = din ^ crc_q[W-1];
    crc_d = crc_q;
    if (clear) begin
      crc_d = SEED;
    end else if (shift_en) begin
      crc_d = {crc_q[W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) crc_q <= SEED;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc_encoder.sv
// Serialises handshake, token and data packets as sync, PID, body and CRC,
// MSB first, under a bit-level valid/ready handshake.
module crc_encoder
  import crc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_b,
  crc_encoder_if.slave  bus
);

  state_t      state_q, state_d;
  pkt_cls_t    cls_q, cls_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [3:0]  pid_q, pid_d;
  logic [63:0] body_q, body_d;

  logic        accept, fire, last, done_c;
  logic        cur_bit, body_bit;
  logic [6:0]  field_len;
  logic [4:0]  crc5;
  logic [15:0] crc16, crc_tx;
  logic [7:0]  pid_byte;
  logic [2:0]  idx8;
  logic [5:0]  idx64;
  logic [3:0]  idx16;

  assign accept = (state_q == ST_IDLE) && bus.pktInAvail;
  assign fire   = (state_q != ST_IDLE) && bus.bitOutReady;

  always_comb begin
    field_len = SYNC_LEN;
    case (state_q)
      ST_PID:  field_len = PID_LEN;
      ST_BODY: field_len = (cls_q == CLS_TOKEN) ? TOKEN_BODY_LEN : DATA_BODY_LEN;
      ST_CRC:  field_len = (cls_q == CLS_TOKEN) ? CRC5_LEN : CRC16_LEN;
      default: field_len = SYNC_LEN;
    endcase
  end

  assign last = (cnt_q == field_len - 7'd1);

  // The counter is the bit index within the current field, MSB first.
  assign idx8     = 3'd7 - cnt_q[2:0];
  assign idx64    = 6'd63 - cnt_q[5:0];
  assign idx16    = 4'd15 - cnt_q[3:0];
  assign pid_byte = {pid_q, ~pid_q};
  assign body_bit = body_q[idx64];
  // CRC5 is left-aligned so both CRC widths shift out from bit 15 down.
  assign crc_tx   = (cls_q == CLS_TOKEN) ? {~crc5, 11'd0} : ~crc16;

  always_comb begin
    cur_bit = 1'b0;
    case (state_q)
      ST_SYNC: cur_bit = SYNC_PATTERN[idx8];
      ST_PID:  cur_bit = pid_byte[idx8];
      ST_BODY: cur_bit = body_bit;
      ST_CRC:  cur_bit = crc_tx[idx16];
      default: cur_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cnt_d   = cnt_q;
    pid_d   = pid_q;
    body_d  = body_q;
    err_d   = 1'b0;
    done_c  = 1'b0;
    if (state_q == ST_IDLE) begin
      cnt_d = 7'd0;
      if (accept) begin
        pid_d  = bus.pid;
        cls_d  = classify(bus.pid);
        body_d = (classify(bus.pid) == CLS_TOKEN) ? {bus.addr, bus.endp, 53'd0} : bus.data;
        if (classify(bus.pid) == CLS_BAD) err_d = 1'b1;
        else                              state_d = ST_SYNC;
      end
    end else if (fire) begin
      if (last) begin
        cnt_d = 7'd0;
        case (state_q)
          ST_SYNC: state_d = ST_PID;
          ST_PID: begin
            if (cls_q == CLS_HS) begin
              state_d = ST_IDLE;
              done_c  = 1'b1;
            end else begin
              state_d = ST_BODY;
            end
          end
          ST_BODY: state_d = ST_CRC;
          ST_CRC: begin
            state_d = ST_IDLE;
            done_c  = 1'b1;
          end
          default: state_d = ST_IDLE;
        endcase
      end else begin
        cnt_d = cnt_q + 7'd1;
      end
    end
  end

  // Control state
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_BAD;
      cnt_q   <= 7'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Captured packet fields
  always_ff @(posedge clk) begin
    pid_q  <= pid_d;
    body_q <= body_d;
  end

  // The CRC registers only move while body bits are accepted, so they hold
  // their final value for the whole Crc state.
  crc_lfsr #(
    .W    (5),
    .POLY (CRC5_POLY),
    .SEED (CRC5_SEED)
  ) u_crc5 (
    .clk      (clk),
    .rst_b    (rst_b),
    .clear    (accept),
    .shift_en (fire && (state_q == ST_BODY) && (cls_q == CLS_TOKEN)),
    .din      (body_bit),
    .crc      (crc5)
  );

  crc_lfsr #(
    .W    (16),
    .POLY (CRC16_POLY),
    .SEED (CRC16_SEED)
  ) u_crc16 (
    .clk      (clk),
    .rst_b    (rst_b),
    .clear    (accept),
    .shift_en (fire && (state_q == ST_BODY) && (cls_q == CLS_DATA)),
    .din      (body_bit),
    .crc      (crc16)
  );

  assign bus.readyIn     = (state_q == ST_IDLE);
  assign bus.bitOutAvail = (state_q != ST_IDLE);
  assign bus.bitOut      = cur_bit;
  assign bus.done        = done_c;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_crc_encoder.sv
// Bench for crc_encoder: directed packets plus randomized traffic against a
// polynomial-division packet model.
module tb_crc_encoder;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  crc_encoder_if bus();

  crc_encoder dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of a seeded CRC by long division: the all-ones seed is
  // equivalent to inverting the first w message bits.
  function automatic logic [15:0] crc_rem(input bit msg[$], input int w, input logic [16:0] gen);
    bit dd[$];
    logic [15:0] r;
    dd = msg;
    for (int i = 0; i < w; i++) dd[i] = ~dd[i];
    for (int i = 0; i < w; i++) dd.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (dd[i])
        for (int j = 0; j <= w; j++) dd[i+j] = dd[i+j] ^ gen[w-j];
    r = '0;
    for (int j = 0; j < w; j++) r = {r[14:0], dd[msg.size()+j]};
    return r;
  endfunction

  localparam logic [16:0] GEN5  = 17'b00000000000100101;
  localparam logic [16:0] GEN16 = 17'h18005;

  function automatic bit is_tok(input logic [3:0] p); return p[3:1] == 3'b100; endfunction
  function automatic bit is_dat(input logic [3:0] p); return p == 4'b1100;     endfunction
  function automatic bit is_hs (input logic [3:0] p); return p[3:1] == 3'b010; endfunction

  function automatic void build(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                                input logic [63:0] d, output bit q[$]);
    bit body[$];
    logic [15:0] c;
    q.delete();
    for (int i = 7; i >= 0; i--) q.push_back(i == 0);
    for (int i = 3; i >= 0; i--) q.push_back(p[i]);
    for (int i = 3; i >= 0; i--) q.push_back(~p[i]);
    if (is_tok(p)) begin
      for (int i = 6; i >= 0; i--) body.push_back(a[i]);
      for (int i = 3; i >= 0; i--) body.push_back(e[i]);
      c = ~crc_rem(body, 5, GEN5);
      foreach (body[i]) q.push_back(body[i]);
      for (int i = 4; i >= 0; i--) q.push_back(c[i]);
    end else if (is_dat(p)) begin
      for (int i = 63; i >= 0; i--) body.push_back(d[i]);
      c = ~crc_rem(body, 16, GEN16);
      foreach (body[i]) q.push_back(body[i]);
      for (int i = 15; i >= 0; i--) q.push_back(c[i]);
    end
  endfunction

  function automatic logic [15:0] tail_rem(input bit q[$], input int n, input int w, input logic [16:0] gen);
    bit t[$];
    for (int i = q.size() - n; i < q.size(); i++) t.push_back(q[i]);
    return crc_rem(t, w, gen);
  endfunction

  // Packet decoder used for loopback: sync, PID check and CRC residue.
  function automatic bit decode_ok(input bit q[$]);
    logic [3:0] p, pc;
    if (q.size() < 16) return 1'b0;
    for (int i = 0; i < 8; i++) if (q[i] != (i == 7)) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      p[3-i]  = q[8+i];
      pc[3-i] = q[12+i];
    end
    if (pc != ~p) return 1'b0;
    if (is_hs(p))  return q.size() == 16;
    if (is_tok(p)) return (q.size() == 32) && (tail_rem(q, 16, 5, GEN5) == 16'h000C);
    if (is_dat(p)) return (q.size() == 96) && (tail_rem(q, 80, 16, GEN16) == 16'h800D);
    return 1'b0;
  endfunction

  function automatic int qdiff(input bit a[$], input bit b[$]);
    int n;
    n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) n++;
    return n;
  endfunction

  task automatic do_accept(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e, input logic [63:0] d);
    int w = 0;
    @(negedge clk);
    while (!bus.readyIn && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.readyIn) chk("accept_wait", bus.readyIn, 1);
    bus.pid = p; bus.addr = a; bus.endp = e; bus.data = d;
    bus.pktInAvail = 1'b1;
    @(posedge clk);
    #1;
    bus.pktInAvail = 1'b0;
    bus.pid  = 4'($urandom);
    bus.addr = 7'($urandom);
    bus.endp = 4'($urandom);
    bus.data = {$urandom, $urandom};
  endtask

  // mode 0: always ready, 1: ready on even cycles, 2: random ready
  task automatic run_pkt(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e, input logic [63:0] d,
                         input int mode, output bit got[$], output int lat, output int stall_bad,
                         output int done_cnt, output int rdy_bad, output bit first_avail);
    bit   prev_stalled = 1'b0;
    logic prev_bit = 1'b0;
    int   cyc = 0;
    got.delete(); lat = -1; stall_bad = 0; done_cnt = 0; rdy_bad = 0; first_avail = 1'b0;
    do_accept(p, a, e, d);
    while (lat < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       bus.bitOutReady = 1'b1;
        1:       bus.bitOutReady = (cyc % 2 == 0);
        default: bus.bitOutReady = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (cyc == 1) first_avail = bus.bitOutAvail;
      if (bus.bitOutAvail && bus.readyIn) rdy_bad++;
      if (prev_stalled && bus.bitOut !== prev_bit) stall_bad++;
      if (bus.done) begin
        done_cnt++;
        lat = cyc;
      end
      if (bus.bitOutAvail && bus.bitOutReady) got.push_back(bus.bitOut);
      prev_stalled = bus.bitOutAvail && !bus.bitOutReady;
      prev_bit     = bus.bitOut;
    end
    if (lat < 0) chk("done_timeout", bus.done, 1);
  endtask

  task automatic post_idle(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_ready_after"}, bus.readyIn, 1);
    chk({tag, "_avail_after"}, bus.bitOutAvail, 0);
  endtask

  bit   got[$], exp_q[$], ref_data[$];
  int   lat, stall_bad, done_cnt, rdy_bad, nbits, cyc, bad;
  bit   fa;
  logic [15:0] hs_word;

  initial begin
    bus.pktInAvail = 1'b0; bus.pid = '0; bus.addr = '0; bus.endp = '0; bus.data = '0;
    bus.bitOutReady = 1'b0;
    #12;
    chk("rst_ready", bus.readyIn, 1);
    chk("rst_avail", bus.bitOutAvail, 0);
    chk("rst_bit",   bus.bitOut, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_err",   bus.err, 0);
    @(negedge clk);
    rst_b = 1'b1;

    // Handshake
    run_pkt(4'b0100, 7'h00, 4'h0, 64'h0, 0, got, lat, stall_bad, done_cnt, rdy_bad, fa);
    hs_word = '0;
    foreach (got[i]) if (i < 16) hs_word[15-i] = got[i];
    chk("hs_len", got.size(), 16);
    chk("hs_bits", hs_word, 16'b0000000101001011);
    chk("hs_lat", lat, 16);
    chk("hs_first_avail", fa, 1);
    chk("hs_done_cnt", done_cnt, 1);
    post_idle("hs");

    // Token
    run_pkt(4'b1000, 7'h15, 4'hE, 64'h0, 0, got, lat, stall_bad, done_cnt, rdy_bad, fa);
    build(4'b1000, 7'h15, 4'hE, 64'h0, exp_q);
    chk("tok_len", got.size(), 32);
    chk("tok_bits_diff", qdiff(got, exp_q), 0);
    chk("tok_residue", tail_rem(got, 16, 5, GEN5), 16'h000C);
    chk("tok_lat", lat, 32);
    chk("tok_ready_busy", rdy_bad, 0);
    post_idle("tok");

    // Data at full rate
    run_pkt(4'b1100, 7'h00, 4'h0, 64'h0123456789ABCDEF, 0, got, lat, stall_bad, done_cnt, rdy_bad, fa);
    build(4'b1100, 7'h00, 4'h0, 64'h0123456789ABCDEF, exp_q);
    ref_data = got;
    chk("dat_len", got.size(), 96);
    chk("dat_bits_diff", qdiff(got, exp_q), 0);
    chk("dat_residue", tail_rem(got, 80, 16, GEN16), 16'h800D);
    chk("dat_decode_valid", decode_ok(got), 1);
    chk("dat_lat", lat, 96);
    post_idle("dat");

    // Data with bitOutReady toggling
    run_pkt(4'b1100, 7'h00, 4'h0, 64'h0123456789ABCDEF, 1, got, lat, stall_bad, done_cnt, rdy_bad, fa);
    chk("stall_bits_diff", qdiff(got, ref_data), 0);
    chk("stall_lat", lat, 192);
    chk("stall_hold", stall_bad, 0);
    chk("stall_done_cnt", done_cnt, 1);
    post_idle("stall");

    // Unsupported PID
    do_accept(4'b0000, 7'h7F, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    #1;
    chk("bad_err", bus.err, 1);
    chk("bad_avail", bus.bitOutAvail, 0);
    chk("bad_ready", bus.readyIn, 1);
    @(negedge clk);
    #1;
    chk("bad_err_pulse", bus.err, 0);
    chk("bad_avail2", bus.bitOutAvail, 0);

    // Reset in the middle of a token
    do_accept(4'b1000, 7'h15, 4'hE, 64'h0);
    bus.bitOutReady = 1'b1;
    nbits = 0;
    cyc = 0;
    while (nbits < 20 && cyc < 100) begin
      @(negedge clk);
      #1;
      if (bus.bitOutAvail && bus.bitOutReady) nbits++;
      cyc++;
    end
    chk("rstmid_reach20", nbits, 20);
    rst_b = 1'b0;
    #1;
    chk("rstmid_avail", bus.bitOutAvail, 0);
    chk("rstmid_bit", bus.bitOut, 0);
    chk("rstmid_done", bus.done, 0);
    chk("rstmid_err", bus.err, 0);
    chk("rstmid_ready", bus.readyIn, 1);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (bus.done || bus.bitOutAvail) bad++;
    end
    chk("rstmid_hold", bad, 0);
    @(negedge clk);
    rst_b = 1'b1;
    run_pkt(4'b0100, 7'h00, 4'h0, 64'h0, 0, got, lat, stall_bad, done_cnt, rdy_bad, fa);
    build(4'b0100, 7'h00, 4'h0, 64'h0, exp_q);
    chk("rstmid_hs_diff", qdiff(got, exp_q), 0);
    chk("rstmid_hs_lat", lat, 16);
    post_idle("rstmid");

    // Randomized traffic
    for (int k = 0; k < 24; k++) begin
      logic [3:0]  p;
      logic [6:0]  a;
      logic [3:0]  e;
      logic [63:0] d;
      int          mode;
      case ($urandom_range(0, 5))
        0: p = 4'b1000;
        1: p = 4'b1001;
        2: p = 4'b1100;
        3: p = 4'b0100;
        4: p = 4'b0101;
        default: p = 4'($urandom);
      endcase
      a = 7'($urandom);
      e = 4'($urandom);
      d = {$urandom, $urandom};
      mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      if (is_tok(p) || is_dat(p) || is_hs(p)) begin
        run_pkt(p, a, e, d, mode, got, lat, stall_bad, done_cnt, rdy_bad, fa);
        build(p, a, e, d, exp_q);
        chk($sformatf("rnd%0d_bits_diff", k), qdiff(got, exp_q), 0);
        chk($sformatf("rnd%0d_done_cnt", k), done_cnt, 1);
        chk($sformatf("rnd%0d_hold", k), stall_bad + rdy_bad, 0);
        if (mode == 0) chk($sformatf("rnd%0d_lat", k), lat, exp_q.size());
        post_idle($sformatf("rnd%0d", k));
      end else begin
        do_accept(p, a, e, d);
        @(negedge clk);
        #1;
        chk($sformatf("rnd%0d_err", k), bus.err, 1);
        chk($sformatf("rnd%0d_noavail", k), bus.bitOutAvail, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
